// File: rtl/frame_config_loader.sv
// frame_config_loader: assembles column frames from a 32-bit config word stream
// and pulses a one-hot FrameStrobe. Optional checksum check: CONFIG_CHECKSUM_EN.
`default_nettype none

module frame_config_loader #(
  parameter int FrameBitsPerRow = 32,
  parameter int NumberOfRows    = 4,
  parameter int MaxFramesPerCol = 20,
  parameter int NumberOfCols    = 8,
  parameter int ColSelectWidth  = 3
) (
  input  logic                                    CLK,
  input  logic                                    RESET,
  input  logic [FrameBitsPerRow-1:0]              WordData,
  input  logic                                    WordValid,
  output logic                                    WordReady,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [ColSelectWidth-1:0]               ColSelect,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    Configured,
  output logic                                    Error
);

  localparam int RowW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [31:0] c_SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] c_DESYNC = 32'hFAB0_FAB0;
  localparam logic [RowW-1:0] c_LAST_ROW = RowW'(NumberOfRows - 1);
  localparam logic [MaxFramesPerCol-1:0] c_ONE = {{(MaxFramesPerCol-1){1'b0}}, 1'b1};

`ifdef CONFIG_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_CHECK  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4
  } state_t;
`endif

  state_t                                 state_q, state_d;
  logic [RowW-1:0]                        row_q, row_d;
  logic [4:0]                             index_q, index_d;
  logic [ColSelectWidth-1:0]              col_q, col_d;
  logic [NumberOfRows*FrameBitsPerRow-1:0] frame_q, frame_d;
  logic [MaxFramesPerCol-1:0]             strobe_q, strobe_d;
  logic                                   configured_q, configured_d;
  logic                                   error_q, error_d;
`ifdef CONFIG_CHECKSUM_EN
  logic [FrameBitsPerRow-1:0]             csum_q, csum_d;
`endif

  logic w_accept;
  logic w_bad_header;

  assign WordReady = (state_q != S_STROBE) && (state_q != S_HOLD);
  assign w_accept  = WordValid && WordReady;

  assign w_bad_header = (WordData[31:28] != 4'h8)
                     || (32'(WordData[20:16]) >= 32'(MaxFramesPerCol))
                     || (32'(WordData[7:0])   >= 32'(NumberOfCols));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      index_q      <= '0;
      col_q        <= '0;
      frame_q      <= '0;
      strobe_q     <= '0;
      configured_q <= 1'b0;
      error_q      <= 1'b0;
`ifdef CONFIG_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      index_q      <= index_d;
      col_q        <= col_d;
      frame_q      <= frame_d;
      strobe_q     <= strobe_d;
      configured_q <= configured_d;
      error_q      <= error_d;
`ifdef CONFIG_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    index_d      = index_q;
    col_d        = col_q;
    frame_d      = frame_q;
    strobe_d     = '0;
    configured_d = configured_q;
    error_d      = error_q;
`ifdef CONFIG_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (w_accept && WordData == c_SYNC) begin
          state_d      = S_HEADER;
          configured_d = 1'b0;
          error_d      = 1'b0;
`ifdef CONFIG_CHECKSUM_EN
          csum_d       = '0;
`endif
        end
      end
      S_HEADER: begin
        if (w_accept) begin
          if (WordData == c_DESYNC) begin
`ifdef CONFIG_CHECKSUM_EN
            state_d      = S_CHECK;
`else
            state_d      = S_IDLE;
            configured_d = 1'b1;
`endif
          end else if (WordData == c_SYNC) begin
            state_d = S_HEADER;
          end else if (w_bad_header) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            index_d = WordData[20:16];
            col_d   = WordData[ColSelectWidth-1:0];
            row_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        // SYNC/DESYNC patterns are ordinary payload here
        if (w_accept) begin
          frame_d[row_q*FrameBitsPerRow +: FrameBitsPerRow] = WordData;
`ifdef CONFIG_CHECKSUM_EN
          csum_d = csum_q ^ WordData;
`endif
          if (row_q == c_LAST_ROW) begin
            row_d    = '0;
            strobe_d = c_ONE << index_q;
            state_d  = S_STROBE;
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end
      S_STROBE: state_d = S_HOLD;
      S_HOLD:   state_d = S_HEADER;
`ifdef CONFIG_CHECKSUM_EN
      S_CHECK: begin
        if (w_accept) begin
          if (WordData == csum_q) configured_d = 1'b1;
          else                    error_d      = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign FrameData   = frame_q;
  assign ColSelect   = col_q;
  assign FrameStrobe = strobe_q;
  assign Configured  = configured_q;
  assign Error       = error_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_config_loader.sv
// tb_frame_config_loader: directed self-checking bench for frame_config_loader.
`default_nettype none

module tb_frame_config_loader;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [31:0]  WordData = '0;
  logic         WordValid = 1'b0;
  logic         WordReady;
  logic [127:0] FrameData;
  logic [2:0]   ColSelect;
  logic [19:0]  FrameStrobe;
  logic         Configured;
  logic         Error;

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_cycles = 0;

  frame_config_loader dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .WordData   (WordData),
    .WordValid  (WordValid),
    .WordReady  (WordReady),
    .FrameData  (FrameData),
    .ColSelect  (ColSelect),
    .FrameStrobe(FrameStrobe),
    .Configured (Configured),
    .Error      (Error)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (|FrameStrobe) strobe_cycles++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one word and return #1 after the edge that transfers it.
  task automatic send_word(input logic [31:0] d, input int gap);
    bit done = 0;
    WordData  = d;
    WordValid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      if (WordReady) done = 1;
      @(posedge CLK);
      #1;
    end
    WordValid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
    for (int i = 0; i < gap; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  localparam logic [127:0] FRAME_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] FRAME_B = 128'hFAB0FAB1_55555555_FAB0FAB0_AAAAAAAA;

  task automatic send_frame_a(input int gap);
    send_word(32'h8003_0002, gap);
    send_word(32'h1111_1111, gap);
    send_word(32'h2222_2222, gap);
    send_word(32'h3333_3333, gap);
    send_word(32'h4444_4444, 0);
  endtask

  initial begin
    // reset state
    #12;
    check("rst_ready", WordReady, 1);
    check("rst_data", FrameData, 0);
    check("rst_col", ColSelect, 0);
    check("rst_strobe", FrameStrobe, 0);
    check("rst_cfg", Configured, 0);
    check("rst_err", Error, 0);
    @(negedge CLK);
    RESET = 1'b0;
    step();

    // basic frame: strobe the cycle after the 4th word, ready low 2 cycles
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'hFAB0_FAB1, 0);
    send_frame_a(0);
    check("a_strobe", FrameStrobe, 20'h00008);
    check("a_ready0", WordReady, 0);
    check("a_col", ColSelect, 2);
    check("a_data", FrameData, FRAME_A);
    step();
    check("a_strobe_off", FrameStrobe, 0);
    check("a_ready1", WordReady, 0);
    check("a_data_hold", FrameData, FRAME_A);
    step();
    check("a_ready_back", WordReady, 1);

`ifdef CONFIG_CHECKSUM_EN
    send_word(32'hFAB0_FAB0, 0);
    check("ck_pending", Configured, 0);
    send_word(32'h4444_4444, 0);
    check("ck_cfg", Configured, 1);
    check("ck_err", Error, 0);
`else
    send_word(32'hFAB0_FAB0, 0);
    check("desync_cfg", Configured, 1);
`endif

    // bad headers: index, column, tag
    send_word(32'hFAB0_FAB1, 0);
    check("sync_clr_cfg", Configured, 0);
    send_word(32'h8014_0000, 0);
    check("bad_idx_err", Error, 1);
    check("bad_idx_strobe", FrameStrobe, 0);
    // in IDLE a header-like word is dropped
    send_word(32'h8001_0001, 0);
    check("idle_drop_col", ColSelect, 2);
    send_word(32'hFAB0_FAB1, 0);
    check("sync_clr_err", Error, 0);
    send_word(32'h8000_0008, 0);
    check("bad_col_err", Error, 1);
    send_word(32'hFAB0_FAB1, 0);
    send_word(32'h7003_0002, 0);
    check("bad_tag_err", Error, 1);

    // gapped frame with SYNC/DESYNC patterns as payload, max index
    send_word(32'hFAB0_FAB1, 0);
    check("sync_clr_err2", Error, 0);
    send_word(32'h8013_0007, 1);
    send_word(32'hAAAA_AAAA, 1);
    send_word(32'hFAB0_FAB0, 1);
    send_word(32'h5555_5555, 1);
    check("b_no_early_strobe", FrameStrobe, 0);
    send_word(32'hFAB0_FAB1, 0);
    check("b_strobe", FrameStrobe, 20'h80000);
    check("b_col", ColSelect, 7);
    check("b_data", FrameData, FRAME_B);
    check("b_cfg", Configured, 0);
    step();
    check("b_strobe_off", FrameStrobe, 0);
    step();

    // reset mid-frame
    send_word(32'h8001_0003, 0);
    send_word(32'h9999_9999, 0);
    send_word(32'h8888_8888, 0);
    RESET = 1'b1;
    #1;
    check("mr_data", FrameData, 0);
    check("mr_col", ColSelect, 0);
    check("mr_strobe", FrameStrobe, 0);
    check("mr_ready", WordReady, 1);
    step();
    step();
    @(negedge CLK);
    RESET = 1'b0;
    step();
    send_word(32'h1234_5678, 0);
    check("mr_idle_drop", FrameData, 0);
    send_word(32'hFAB0_FAB1, 0);
    send_frame_a(0);
    check("c_strobe", FrameStrobe, 20'h00008);
    check("c_data", FrameData, FRAME_A);
    check("c_col", ColSelect, 2);
    step();
    step();

`ifdef CONFIG_CHECKSUM_EN
    send_word(32'hFAB0_FAB0, 0);
    send_word(32'h0000_0000, 0);
    check("ck_bad_err", Error, 1);
    check("ck_bad_cfg", Configured, 0);
`else
    send_word(32'hFAB0_FAB0, 0);
    check("c_cfg", Configured, 1);
    check("c_err", Error, 0);
`endif

    step();
    check("strobe_cycles", strobe_cycles, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
